// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions: reduction FSM states and field-degree limits.
// Used by gf_reduce and the neighbouring gf_* datapath stages.
package gf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } gf_state_e;

    localparam int GF_DATA_WIDTH = 32;
    localparam int WIDTH_W       = $clog2(GF_DATA_WIDTH) + 1;
    localparam int MIN_WIDTH     = 2;

endpackage

// File: rtl/gf_reduce_step.sv
// One MSB-first reduction step: clears bit idx of r by folding in the
// modulus aligned so that its implicit x^m term lands on bit idx.
module gf_reduce_step
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0]             r,
    input  logic [$clog2(2*DATA_WIDTH)-1:0]     idx,
    input  logic [$clog2(DATA_WIDTH):0]         m,
    input  logic [DATA_WIDTH:0]                 poly_full,
    output logic [2*DATA_WIDTH-1:0]             r_next
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int IW = $clog2(2 * DATA_WIDTH);

    logic [IW-1:0] shift_s;
    logic [PW-1:0] poly_ext_s;

    // Conditional xor of the shifted modulus into the remainder
    always_comb begin
        shift_s    = idx - IW'(m);
        poly_ext_s = PW'(poly_full) << shift_s;
        if (r[idx]) begin
            r_next = r ^ poly_ext_s;
        end else begin
            r_next = r;
        end
    end

endmodule

// File: rtl/gf_reduce.sv
// Sequential GF(2^m) reduction of a carry-less product, one bit per cycle.
// Build option GF_REDUCE_EARLY_EXIT_EN: finish as soon as the remaining high bits are zero.
module gf_reduce
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [$clog2(DATA_WIDTH):0]     in_width,
    input  logic [DATA_WIDTH-1:0]           in_poly,
    input  logic [2*DATA_WIDTH-1:0]         in_product,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_result,
    output logic                            out_error
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int IW = $clog2(2 * DATA_WIDTH);
    localparam int WW = $clog2(DATA_WIDTH) + 1;

    gf_state_e               state_r, state_s;
    logic [PW-1:0]           r_r, r_next_s;
    logic [IW-1:0]           idx_r;
    logic [WW-1:0]           m_r;
    logic [DATA_WIDTH:0]     poly_r;
    logic                    in_ready_r, out_valid_r, out_error_r;
    logic [DATA_WIDTH-1:0]   out_result_r;

    logic                    width_ok_s, last_s;
    logic [WW:0]             width2_s;
    logic [IW-1:0]           top_idx_s;
    logic [PW-1:0]           prod_mask_s;
    logic [DATA_WIDTH-1:0]   poly_mask_s;
    logic [DATA_WIDTH:0]     poly_full_s;

    gf_reduce_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .r         (r_r),
        .idx       (idx_r),
        .m         (m_r),
        .poly_full (poly_full_s_reg_sel()),
        .r_next    (r_next_s)
    );

    function automatic logic [DATA_WIDTH:0] poly_full_s_reg_sel();
        return poly_r;
    endfunction

    // Capture-side decode: width legality, product/poly masks, starting index
    always_comb begin
        width_ok_s  = (in_width >= WW'(MIN_WIDTH)) && (in_width <= WW'(DATA_WIDTH));
        width2_s    = {in_width, 1'b0};
        top_idx_s   = IW'(width2_s - (WW+1)'(2));
        prod_mask_s = ~({PW{1'b1}} << (width2_s - (WW+1)'(1)));
        poly_mask_s = ~({DATA_WIDTH{1'b1}} << in_width);
        poly_full_s = {1'b0, in_poly & poly_mask_s} | ((DATA_WIDTH+1)'(1) << in_width);
    end

`ifdef GF_REDUCE_EARLY_EXIT_EN
    logic [IW-1:0] span_s;
    logic          hi_zero_s;

    // Stop once every remaining bit at or above x^m is already clear
    always_comb begin
        span_s    = idx_r - IW'(m_r) + IW'(1);
        hi_zero_s = ((r_r >> m_r) & ~({PW{1'b1}} << span_s)) == {PW{1'b0}};
        last_s    = (idx_r == IW'(m_r)) || hi_zero_s;
    end
`else
    // Fixed schedule: the step at idx == m is always the final one
    always_comb begin
        last_s = (idx_r == IW'(m_r));
    end
`endif

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = width_ok_s ? ST_REDUCE : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REDUCE: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_REDUCE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and handshake flags, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
        end
    end

    // Operand capture, reduction datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r          <= {PW{1'b0}};
            idx_r        <= {IW{1'b0}};
            m_r          <= {WW{1'b0}};
            poly_r       <= {(DATA_WIDTH+1){1'b0}};
            out_result_r <= {DATA_WIDTH{1'b0}};
            out_error_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && width_ok_s) begin
                        r_r   <= in_product & prod_mask_s;
                        idx_r <= top_idx_s;
                        m_r   <= in_width;
                        poly_r <= poly_full_s;
                    end else if (in_valid) begin
                        out_result_r <= {DATA_WIDTH{1'b0}};
                        out_error_r  <= 1'b1;
                    end
                end
                ST_REDUCE: begin
                    r_r   <= r_next_s;
                    idx_r <= idx_r - IW'(1);
                    if (last_s) begin
                        // Bits >= m are clear here, so the low word is the element
                        out_result_r <= r_next_s[DATA_WIDTH-1:0];
                        out_error_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_result_r <= {DATA_WIDTH{1'b0}};
                        out_error_r  <= 1'b0;
                    end
                end
                default: begin
                    r_r <= {PW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_error  = out_error_r;

endmodule

// File: tb/tb_gf_reduce.sv
// Directed self-checking bench for gf_reduce with hand-computed GF(2^m) remainders.
module tb_gf_reduce;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_width = 6'd8;
    logic [31:0] in_poly = 32'h0;
    logic [63:0] in_product = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_error;

    int total = 0;
    int bad = 0;
    int lat;

    gf_reduce #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_width   (in_width),
        .in_poly    (in_poly),
        .in_product (in_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_error  (out_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [5:0] w, input logic [31:0] p, input logic [63:0] prod);
        @(negedge clk);
        in_width   = w;
        in_poly    = p;
        in_product = prod;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // lat counts cycles from the capture cycle T, so out_valid seen in cycle T+n gives n
    task automatic wait_done(output int n);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_lat(input string tag, input int obs, input int m, input int exp, input bit exact);
`ifdef GF_REDUCE_EARLY_EXIT_EN
        if (exact) check(tag, 64'(obs), 64'(exp));
        else       check(tag, 64'((obs >= 2) && (obs <= m)), 64'd1);
`else
        check(tag, 64'(obs), 64'(exp));
`endif
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_error", 64'(out_error), 64'd0);
        rst_n = 1'b1;

        // AES field: 0x57 * 0x83
        start_op(6'd8, 32'h1B, 64'h2B79);
        check("aes_busy", 64'(in_ready), 64'd0);
        wait_done(lat);
        check_lat("aes_lat", lat, 8, 8, 1'b0);
        check("aes_res", 64'(out_result), 64'hC1);
        check("aes_err", 64'(out_error), 64'd0);
        accept("aes");

        start_op(6'd4, 32'h3, 64'h40);
        wait_done(lat);
        check_lat("m4_lat", lat, 4, 4, 1'b0);
        check("m4_res", 64'(out_result), 64'hC);
        accept("m4");

        start_op(6'd2, 32'h3, 64'h4);
        wait_done(lat);
        check_lat("m2_lat", lat, 2, 2, 1'b1);
        check("m2_res", 64'(out_result), 64'h3);
        accept("m2");

        start_op(6'd8, 32'h1B, 64'h00A5);
`ifdef GF_REDUCE_EARLY_EXIT_EN
        wait_done(lat);
        check_lat("a5_lat", lat, 8, 2, 1'b1);
`else
        wait_done(lat);
        check_lat("a5_lat", lat, 8, 8, 1'b1);
`endif
        check("a5_res", 64'(out_result), 64'hA5);
        accept("a5");

        // Junk above bit 2m-2 must be masked off
        start_op(6'd8, 32'h1B, 64'hFFFF_0000_2B79);
        wait_done(lat);
        check("mask_res", 64'(out_result), 64'hC1);
        accept("mask");

        // Hold result with out_ready low; in_valid pulse in DONE is ignored
        start_op(6'd8, 32'h1B, 64'h2B79);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = (i == 2);
            in_product = 64'h4;
            in_width   = 6'd2;
            @(posedge clk);
            #1;
            check("hold_vld", 64'(out_valid), 64'd1);
            check("hold_res", 64'(out_result), 64'hC1);
            check("hold_rdy", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        accept("hold");
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_ghost", 64'(out_valid), 64'd0);

        // Illegal widths complete immediately with an error
        start_op(6'd1, 32'h3, 64'h2B79);
        wait_done(lat);
        check("w1_lat", 64'(lat), 64'd1);
        check("w1_err", 64'(out_error), 64'd1);
        check("w1_res", 64'(out_result), 64'd0);
        accept("w1");

        start_op(6'd33, 32'h3, 64'h2B79);
        wait_done(lat);
        check("w33_err", 64'(out_error), 64'd1);
        check("w33_res", 64'(out_result), 64'd0);
        accept("w33");

        // Consumer already ready when result appears: one-cycle out_valid
        out_ready = 1'b1;
        start_op(6'd4, 32'h3, 64'h40);
        wait_done(lat);
        check("same_res", 64'(out_result), 64'hC);
        @(posedge clk);
        #1;
        check("same_vld_drop", 64'(out_valid), 64'd0);
        check("same_idle", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a reduction
        start_op(6'd8, 32'h1B, 64'h2B79);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_vld", 64'(out_valid), 64'd0);
        check("midrst_rdy", 64'(in_ready), 64'd1);
        check("midrst_res", 64'(out_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(6'd8, 32'h1B, 64'h2B79);
        wait_done(lat);
        check("post_rst_res", 64'(out_result), 64'hC1);
        accept("post_rst");

        // Full width: x^62 mod (x^32+x^7+x^3+x^2+1) = x^30+x^12+x^5+x^4+x^2+x+1
        start_op(6'd32, 32'h8D, 64'h1 << 62);
        wait_done(lat);
        check_lat("m32_lat", lat, 32, 32, 1'b0);
        check("m32_res", 64'(out_result), 64'h4000_1037);
        check("m32_err", 64'(out_error), 64'd0);
        accept("m32");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
